wb_sdram_pattern_master: RTL
============================

# wb_sdram_pattern_master

Wishbone initiator that drives the Wishbone slave port of the SDRAM controller top with a deterministic write-then-readback traffic pattern. It waits for SDRAM init, writes a region, reads it back, compares each word and reports an error count. It is the bus-side counterpart to the controller's responder port, used for bring-up and self-test in place of a procedural testcase.

## Interface
- `AW`, 26, Wishbone byte-address width.
- `DW`, 32, data width (fixed 32; `wb_sel_o` is 4 bits).
- `BURST_LEN`, 8, maximum beats per burst (power of two, 2..16).
- `TIMEOUT`, 1024, cycles without ack before abort.

Ports:
- `wb_clk_i` in 1: single clock. All logic is synchronous to it.
- `wb_resetn` in 1: asynchronous, active-low reset.
- `start` in 1: pulse that launches a run. It is sampled only in IDLE.
- `base_addr` in AW: byte address of the first word. Bits [1:0] are ignored and forced to 0.
- `num_words` in 16: number of 32-bit words; 0 is legal.
- `sdr_init_done` in 1: controller init complete.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1 each.
- `wb_addr_o` out AW, `wb_dat_o` out 32, `wb_sel_o` out 4, `wb_cti_o` out 3.
- `wb_ack_i` in 1, `wb_dat_i` in 32.
- `busy` out 1: high from accepted start until done.
- `done` out 1: one-cycle pulse at end of run.
- `err_cnt` out 16: readback mismatches, saturating at 0xFFFF.
- `first_err_addr` out AW: address of the first mismatch. Valid when `err_cnt != 0`.
- `timeout` out 1: sticky abort flag, cleared on the next accepted start.

## Operation
- FSM states: IDLE, WAIT_INIT, WRITE, WGAP, READ, RGAP, DONE.
- IDLE → WAIT_INIT on `start`. On acceptance, latch `base_addr`/`num_words` and clear `err_cnt`, `first_err_addr` and `timeout`. A `start` outside IDLE is ignored.
- WAIT_INIT → WRITE when `sdr_init_done` is high. If `num_words == 0`, go straight to DONE.
- Word index k runs 0..num_words-1. Address is base + 4k. Pattern is `{~k[15:0], k[15:0]}`. `wb_sel_o` = 4'hF.
- WRITE: `cyc`/`stb`/`we` are high with address and data of the current k, held stable until `wb_ack_i`. On ack, k increments.
  - After the last write ack, go to RGAP with k reset to 0.
  - Otherwise go to WGAP for one idle cycle (`cyc`/`stb` low), then back to WRITE.
- READ: same as WRITE with `we` low.
  - On ack, compare `wb_dat_i` with the expected pattern. On mismatch, increment `err_cnt` (saturating) and capture `first_err_addr` if `err_cnt` was 0.
  - After the last read ack, go to DONE. Otherwise go to RGAP, then back to READ.
- Watchdog: a counter runs while `stb` is high without ack. Reaching TIMEOUT sets `timeout`, drops `cyc`/`stb` and goes to DONE.
- DONE: pulse `done` for 1 cycle, then IDLE.
- `wb_ack_i` while `stb` is low is ignored.

## Timing
- Reset values: `cyc`, `stb`, `we` = 0. `addr`, `dat` = 0. `sel` = 0. `cti` = 3'b000. `busy`, `done`, `timeout` = 0. `err_cnt`, `first_err_addr` = 0. FSM = IDLE.
- Reset asserted mid-run drops the bus immediately, without waiting for the clock edge.
- `start` at edge N: `busy` = 1 after edge N. The first `stb` rises after edge N+1 if `sdr_init_done` was already high.
- All outputs are registered. Ack at edge M means the next-word address/data appear after edge M.
- In non-burst mode, each single transfer is separated by one idle cycle (WGAP/RGAP).
- `busy` falls in the same cycle `done` pulses.

## Configuration
- `WB_PATTERN_BURST_EN` defined: transfers are grouped into incrementing bursts of up to BURST_LEN beats.
  - A burst never crosses a BURST_LEN×4-byte aligned boundary and never exceeds the remaining words.
  - Beats use `cti` = 3'b010 and the final beat uses 3'b111.
  - `cyc`/`stb` stay high across all beats of the burst, with address advancing on each ack. WGAP/RGAP occur only between bursts.
- `WB_PATTERN_BURST_EN` undefined: classic single cycles only. `cti` = 3'b000 always.

## Test plan
- Reset, `sdr_init_done` = 1, start with base 0x0000100 and num_words 4.
  - Expect writes at 0x100, 0x104, 0x108, 0x10C with data 0xFFFF0000, 0xFFFE0001, 0xFFFD0002, 0xFFFC0003, then 4 reads.
  - Expect `err_cnt` = 0 and one `done` pulse.
- Hold `sdr_init_done` = 0 for 500 cycles after start → no `cyc` activity and `busy` = 1. The run proceeds after `sdr_init_done` rises.
- Slave corrupts read word k = 2 (base 0x200) to 0 → `err_cnt` = 1 and `first_err_addr` = 0x208.
- Slave never acks → after 1024 stalled cycles, `timeout` = 1, `cyc` = 0 and `done` pulses. A new start clears `timeout`.
- num_words = 0 → `done` 2 cycles after start, no bus cycle, `err_cnt` = 0. A second start pulsed while busy is ignored.
- With `WB_PATTERN_BURST_EN`, num_words 10 at base 0x18 (BURST_LEN 8):
  - Bursts are 2 beats (0x18, 0x1C), 8 beats (0x20..0x3C), then 0 remaining words.
  - `cti` on the last beat of each burst is 3'b111.
  - Asserting reset mid-burst drops `cyc` without waiting for the clock edge.

Source files
------------

// File: rtl/wb_sdram_pattern_master.sv
// rtl/wb_sdram_pattern_master.sv - Wishbone write-then-readback pattern initiator for SDRAM self-test
//
// Waits for SDRAM init, writes {~k,k} to num_words words from base_addr, reads them
// back and counts mismatches. A watchdog aborts a stalled transfer after TIMEOUT cycles.
//
// Ports:
//   wb_clk_i, wb_resetn        clock, asynchronous active-low reset
//   start, base_addr, num_words run launch (sampled in IDLE only) and run parameters
//   sdr_init_done               controller init complete
//   wb_cyc_o .. wb_cti_o        Wishbone initiator outputs (all registered)
//   wb_ack_i, wb_dat_i          Wishbone slave response
//   busy, done, err_cnt, first_err_addr, timeout   run status
//
// Optional feature: define WB_PATTERN_BURST_EN for incrementing bursts of up to
// BURST_LEN beats that never cross a BURST_LEN*4-byte aligned boundary.
module wb_sdram_pattern_master #(
    parameter int AW        = 26,
    parameter int DW        = 32,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic          wb_clk_i,
    input  logic          wb_resetn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [15:0]   num_words,
    input  logic          sdr_init_done,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic [2:0]    wb_cti_o,
    input  logic          wb_ack_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic          busy,
    output logic          done,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic          timeout
);

`ifdef WB_PATTERN_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif
    localparam int LB  = $clog2(BURST_LEN);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_INIT, ST_WRITE, ST_WGAP, ST_READ, ST_RGAP, ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   k_q, k_d, num_q, num_d, err_q, err_d;
    logic [AW-1:0] base_q, base_d, addr_q, addr_d, ferr_q, ferr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [2:0]    cti_q, cti_d;
    logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic          busy_q, busy_d, done_q, done_d, tmo_q, tmo_d;
    logic [LB:0]   burst_left_q, burst_left_d;
    logic [WDW-1:0] wdog_q, wdog_d;

    logic [15:0]   beat_idx, remaining, beat_len;
    logic [AW-1:0] beat_addr;
    logic [LB:0]   bound_left;
    logic          ack, launch, cont, drop, launch_we, wd_expired;

    // Next beat to put on the bus: after an ack it is k+1, otherwise k itself.
    always_comb begin
        beat_idx   = (state_q == ST_WRITE || state_q == ST_READ) ? k_q + 16'd1 : k_q;
        beat_addr  = base_q + AW'({beat_idx, 2'b00});
        remaining  = num_q - beat_idx;
        // Words left before the next BURST_LEN*4-byte aligned boundary.
        bound_left = (LB+1)'(BURST_LEN) - {1'b0, beat_addr[LB+1:2]};
        beat_len   = (remaining < 16'(bound_left)) ? remaining : 16'(bound_left);
    end

    assign ack        = wb_ack_i & stb_q;
    assign wd_expired = (wdog_q == WDW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        num_d        = num_q;
        base_d       = base_q;
        err_d        = err_q;
        ferr_d       = ferr_q;
        addr_d       = addr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        cti_d        = cti_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tmo_d        = tmo_q;
        burst_left_d = burst_left_q;
        wdog_d       = (stb_q && !wb_ack_i) ? wdog_q + WDW'(1) : '0;
        launch       = 1'b0;
        cont         = 1'b0;
        drop         = 1'b0;
        launch_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT_INIT;
                    base_d  = base_addr & ~AW'(3);
                    num_d   = num_words;
                    k_d     = '0;
                    err_d   = '0;
                    ferr_d  = '0;
                    tmo_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_WAIT_INIT: begin
                if (sdr_init_done) begin
                    if (num_q == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_WRITE;
                        launch    = 1'b1;
                        launch_we = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                launch_we = 1'b1;
                if (ack) begin
                    k_d = k_q + 16'd1;
                    if (k_q + 16'd1 == num_q) begin
                        state_d = ST_RGAP;
                        k_d     = '0;
                        drop    = 1'b1;
                    end else if (BURST_EN && burst_left_q != (LB+1)'(1)) begin
                        cont = 1'b1;
                    end else begin
                        state_d = ST_WGAP;
                        drop    = 1'b1;
                    end
                end else if (wd_expired) begin
                    tmo_d   = 1'b1;
                    drop    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                if (ack) begin
                    if (wb_dat_i != {~k_q, k_q}) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (err_q == 16'd0) ferr_d = addr_q;
                    end
                    k_d = k_q + 16'd1;
                    if (k_q + 16'd1 == num_q) begin
                        state_d = ST_DONE;
                        drop    = 1'b1;
                    end else if (BURST_EN && burst_left_q != (LB+1)'(1)) begin
                        cont = 1'b1;
                    end else begin
                        state_d = ST_RGAP;
                        drop    = 1'b1;
                    end
                end else if (wd_expired) begin
                    tmo_d   = 1'b1;
                    drop    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WGAP: begin
                state_d   = ST_WRITE;
                launch    = 1'b1;
                launch_we = 1'b1;
            end
            ST_RGAP: begin
                state_d = ST_READ;
                launch  = 1'b1;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (launch || cont) begin
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            we_d   = launch_we;
            addr_d = beat_addr;
            dat_d  = {~beat_idx, beat_idx};
            sel_d  = 4'hF;
        end
        if (launch) begin
            burst_left_d = beat_len[LB:0];
            cti_d = !BURST_EN ? 3'b000 : (beat_len == 16'd1) ? 3'b111 : 3'b010;
        end
        if (cont) begin
            burst_left_d = burst_left_q - (LB+1)'(1);
            cti_d = (burst_left_q == (LB+1)'(2)) ? 3'b111 : 3'b010;
        end
        if (drop) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
            cti_d = 3'b000;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            num_q        <= '0;
            base_q       <= '0;
            err_q        <= '0;
            ferr_q       <= '0;
            addr_q       <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            cti_q        <= 3'b000;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tmo_q        <= 1'b0;
            burst_left_q <= '0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            num_q        <= num_d;
            base_q       <= base_d;
            err_q        <= err_d;
            ferr_q       <= ferr_d;
            addr_q       <= addr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            cti_q        <= cti_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tmo_q        <= tmo_d;
            burst_left_q <= burst_left_d;
            wdog_q       <= wdog_d;
        end
    end

    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = stb_q;
    assign wb_we_o        = we_q;
    assign wb_addr_o      = addr_q;
    assign wb_dat_o       = dat_q;
    assign wb_sel_o       = sel_q;
    assign wb_cti_o       = cti_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;
    assign timeout        = tmo_q;

endmodule
